// File: rtl/fpu_f32_accum_seq_if.sv
// Stream and adder-side signals of the FP32 accumulate sequencer.
// The slave modport is the sequencer's view; master is its environment (source, sink, adder).
interface fpu_f32_accum_seq_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_data;
  logic                 in_last;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic [31:0]          add_o;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [CNT_WIDTH-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, add_o, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, add_o, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fpu_f32_accum_seq.sv
// Reduces a packetised FP32 stream to one sum per packet through an external
// combinational FP32 adder, reporting a saturating element count with each sum.
module fpu_f32_accum_seq #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fpu_f32_accum_seq_if.slave      bus
);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ADD    = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  logic [31:0]          acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic                 in_ready_q;
  logic                 out_valid_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // in_ready_q is set by reset so the block is ready the first cycle reset drops;
  // the gate keeps it low while reset is still asserted.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.out_count = cnt;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ACCEPT;
      acc         <= 32'h0000_0000;
      cnt         <= '0;
      last        <= 1'b0;
      add_a       <= 32'h0000_0000;
      add_b       <= 32'h0000_0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_ACCEPT: begin
          // Operands only move on a transfer, so the adder is quiet while idle.
          if (bus.in_valid && in_ready_q) begin
            add_a      <= acc;
            add_b      <= bus.in_data;
            last       <= bus.in_last;
            in_ready_q <= 1'b0;
            state      <= S_ADD;
          end
        end
        S_ADD: begin
          acc <= bus.add_o;
          cnt <= sat_inc(cnt);
          if (last) begin
            out_valid_q <= 1'b1;
            state       <= S_OUT;
          end else begin
            in_ready_q <= 1'b1;
            state      <= S_ACCEPT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            acc         <= 32'h0000_0000;
            cnt         <= '0;
            last        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_ACCEPT;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= S_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_f32_accum_seq.sv
// Directed bench for fpu_f32_accum_seq; a table-driven stand-in for the FP32 adder
// returns hand-computed sums for the operand pairs the vectors produce.
module tb_fpu_f32_accum_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fpu_f32_accum_seq_if #(.CNT_WIDTH(16)) b0 ();
  fpu_f32_accum_seq_if #(.CNT_WIDTH(2))  b1 ();

  fpu_f32_accum_seq #(.CNT_WIDTH(16)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fpu_f32_accum_seq #(.CNT_WIDTH(2))  dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Hand-computed FP32 sums (RNE); unknown pairs give a poison value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h00000000, 32'h3F800000}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h00000000, 32'h80000000}: return 32'h00000000;
      {32'h00000000, 32'h3FC00000}: return 32'h3FC00000;
      {32'h00000000, 32'h40000000}: return 32'h40000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'h40800000, 32'h3F800000}: return 32'h40A00000;
      {32'h3F800000, 32'hBF800000}: return 32'h00000000;
      {32'h00000000, 32'h00000000}: return 32'h00000000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  assign b0.add_o = fadd(b0.add_a, b0.add_b);
  assign b1.add_o = fadd(b1.add_a, b1.add_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the transfer edge.
  task automatic push(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    b0.in_last  = l;
    while (!b0.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("push_timeout", 32'(b0.in_ready), 32'd1);
    step();
    b0.in_valid = 1'b0;
    b0.in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] d, input logic [31:0] c);
    int n;
    n = 0;
    b0.out_ready = 1'b1;
    while (!b0.out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(b0.out_valid), 32'd1);
    check({tag, "_data"},  b0.out_data, d);
    check({tag, "_count"}, 32'(b0.out_count), c);
    step();
    check({tag, "_drop"},  32'(b0.out_valid), 32'd0);
  endtask

  logic [31:0] t1v [3];
  int          idx;
  logic        xfer;
  int          n;

  initial begin
    t1v[0] = 32'h3F800000; t1v[1] = 32'h40000000; t1v[2] = 32'h40400000;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_in_ready",  32'(b0.in_ready), 32'd0);
    check("rst_out_valid", 32'(b0.out_valid), 32'd0);
    check("rst_add_a",     b0.add_a, 32'h0);
    check("rst_add_b",     b0.add_b, 32'h0);
    check("rst_out_data",  b0.out_data, 32'h0);
    check("rst_out_count", 32'(b0.out_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(b0.in_ready), 32'd1);

    // 1: 1+2+3 with IN_VALID held high
    idx = 0;
    b0.in_valid = 1'b1; b0.in_data = t1v[0]; b0.in_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t1_in_ready", 32'(b0.in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t1_no_out",   32'(b0.out_valid), 32'd0);
      xfer = b0.in_valid && b0.in_ready;
      step();
      if (xfer) begin
        idx++;
        if (idx < 3) begin
          b0.in_data = t1v[idx];
          b0.in_last = (idx == 2);
        end else begin
          b0.in_valid = 1'b0;
          b0.in_last  = 1'b0;
        end
      end
    end
    check("t1_out_valid", 32'(b0.out_valid), 32'd1);
    check("t1_out_data",  b0.out_data, 32'h40C00000);
    check("t1_out_count", 32'(b0.out_count), 32'd3);
    step();
    check("t1_out_1cyc",  32'(b0.out_valid), 32'd0);
    check("t1_ready_after", 32'(b0.in_ready), 32'd1);

    // 2: -0.0 alone gives +0.0, then accumulator cleared for next packet
    push(32'h80000000, 1'b1);
    wait_out("t2a", 32'h00000000, 32'd1);
    push(32'h3FC00000, 1'b1);
    wait_out("t2b", 32'h3FC00000, 32'd1);

    // 3: output backpressure
    b0.out_ready = 1'b0;
    push(32'h40000000, 1'b1);
    n = 0;
    while (!b0.out_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(b0.out_valid), 32'd1);
      check("t3_hold_data",  b0.out_data, 32'h40000000);
      check("t3_hold_count", 32'(b0.out_count), 32'd1);
      check("t3_in_ready",   32'(b0.in_ready), 32'd0);
      step();
    end
    b0.out_ready = 1'b1;
    check("t3_valid6", 32'(b0.out_valid), 32'd1);
    step();
    check("t3_ready_after", 32'(b0.in_ready), 32'd1);
    check("t3_out_drop",    32'(b0.out_valid), 32'd0);

    // 4: reset during S_ADD of the second element
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b0);
    rst = 1'b1;
    step();
    check("t4_rst_ready", 32'(b0.in_ready), 32'd0);
    check("t4_add_a",     b0.add_a, 32'h0);
    check("t4_add_b",     b0.add_b, 32'h0);
    rst = 1'b0;
    #1;
    check("t4_ready_after", 32'(b0.in_ready), 32'd1);
    push(32'h40000000, 1'b1);
    wait_out("t4", 32'h40000000, 32'd1);

    // 6: gapped input; operands hold between transfers
    push(32'h3F800000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("t6_hold_a", b0.add_a, 32'h00000000);
      check("t6_hold_b", b0.add_b, 32'h3F800000);
      step();
    end
    push(32'hBF800000, 1'b1);
    check("t6_add_a2", b0.add_a, 32'h3F800000);
    check("t6_add_b2", b0.add_b, 32'hBF800000);
    wait_out("t6", 32'h00000000, 32'd2);

    // 5: count saturation with CNT_WIDTH=2
    for (int e = 0; e < 5; e++) begin
      b1.in_valid = 1'b1; b1.in_data = 32'h3F800000; b1.in_last = (e == 4);
      n = 0;
      while (!b1.in_ready && n < 20) begin step(); n++; end
      step();
      b1.in_valid = 1'b0; b1.in_last = 1'b0;
    end
    n = 0;
    while (!b1.out_valid && n < 20) begin step(); n++; end
    check("t5_valid", 32'(b1.out_valid), 32'd1);
    check("t5_data",  b1.out_data, 32'h40A00000);
    check("t5_count", 32'(b1.out_count), 32'd3);
    step();
    check("t5_drop",  32'(b1.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_f32_accum_seq.md
Name: fpu_f32_accum_seq

Overview:
- Sequencer that sits directly around the combinational FP32 adder (FPU_F32_ADD) and reduces a stream of FP32 values to a single sum.
- Drives the adder's A/B operand inputs from registers and captures its O result back into a running accumulator.
- Emits one sum, plus an element count, per packet delimited by IN_LAST.
- Used by the FPU block for dot-product and row-sum reductions.

Parameters:
- CNT_WIDTH, 16, width of the element counter; the count saturates at 2^CNT_WIDTH-1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  input element valid.
- IN_READY  output  1  block can accept an element this cycle.
- IN_DATA  input  32  FP32 element.
- IN_LAST  input  1  element is the last of its packet.
- ADD_A  output  32  registered operand A to the FPU_F32_ADD instance.
- ADD_B  output  32  registered operand B to the FPU_F32_ADD instance.
- ADD_O  input  32  result O from the FPU_F32_ADD instance (combinational from ADD_A/ADD_B).
- OUT_VALID  output  1  packet sum valid.
- OUT_READY  input  1  downstream accepts the sum.
- OUT_DATA  output  32  FP32 packet sum.
- OUT_COUNT  output  CNT_WIDTH  number of elements summed (saturating).

Behaviour:
- Interface decided: one clock CLK; reset RST is synchronous and active-high.
- Reset values, all applied on the cycle RST is sampled high:
  - FSM to S_ACCEPT.
  - Accumulator to 0x00000000; count to 0; last flag to 0.
  - ADD_A, ADD_B to 0x00000000.
  - OUT_VALID 0; IN_READY 0 during reset, 1 the first cycle after.
- RST has priority over every other event. Reset mid-packet or mid-output discards the partial sum, the count and any pending output.
- Handshakes: transfer occurs when VALID && READY at a rising edge. OUT_DATA and OUT_COUNT hold stable while OUT_VALID=1 && OUT_READY=0.
- FSM states:
  - S_ACCEPT:
    - IN_READY=1, OUT_VALID=0.
    - On input transfer: ADD_A<=acc, ADD_B<=IN_DATA, last<=IN_LAST, go to S_ADD.
    - With no transfer, stay and hold all registers.
  - S_ADD:
    - IN_READY=0. ADD_O is valid combinationally this cycle.
    - acc<=ADD_O.
    - count<=count+1, saturating at all-ones.
    - If last=1, go to S_OUT; else go to S_ACCEPT.
  - S_OUT:
    - OUT_VALID=1, OUT_DATA=acc, OUT_COUNT=count, IN_READY=0.
    - On OUT_READY=1: acc<=0x00000000, count<=0, last<=0, go to S_ACCEPT.
    - Otherwise stay.
- Throughput and latency:
  - One element accepted per 2 cycles; IN_READY toggles 1,0,1,0 under continuous IN_VALID.
  - OUT_VALID rises 2 cycles after the transfer of the IN_LAST element.
  - The next packet's first element is accepted no earlier than the cycle after the OUT transfer.
- Arithmetic:
  - Every element, including the first, is added to an accumulator seeded with +0.0.
  - Consequently a packet of the single element -0.0 yields 0x00000000.
  - NaN, Inf and rounding are entirely the adder's; this block never alters operand or result bits.
- ADD_A and ADD_B change only on an input transfer; they hold otherwise, so there is no adder toggling when idle.
- Count saturation: once count reaches 2^CNT_WIDTH-1, further elements are still summed but the count stays.
- IN_LAST on an element is sampled only at its transfer. There are no zero-length packets: an output requires at least one element.

Test Plan:
1. Packet 0x3F800000, 0x40000000, 0x40400000 (IN_LAST on the 3rd), IN_VALID held high, OUT_READY=1 -> IN_READY pattern 1,0,1,0,1,0; OUT_DATA=0x40C00000, OUT_COUNT=3; OUT_VALID high exactly 1 cycle, 2 cycles after the third transfer.
2. Single element 0x80000000 with IN_LAST -> OUT_DATA=0x00000000, OUT_COUNT=1. Then packet 0x3FC00000 alone -> 0x3FC00000, count 1 (accumulator cleared between packets).
3. Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID rises -> OUT_DATA and OUT_COUNT stable, IN_READY=0 throughout; transfer on cycle 6, IN_READY=1 the next cycle.
4. Reset mid-packet: two elements 0x3F800000 accepted, RST high 1 cycle during S_ADD, then packet 0x40000000 last -> OUT_DATA=0x40000000, OUT_COUNT=1; ADD_A=ADD_B=0 the cycle after reset.
5. CNT_WIDTH=2, five elements of 0x3F800000 with last on the 5th -> OUT_COUNT=3 (saturated), OUT_DATA=0x40A00000.
6. Gapped input: IN_VALID asserted every 3rd cycle for 0x3F800000, 0xBF800000 (last) -> ADD_A/ADD_B stable between transfers; OUT_DATA=0x00000000, OUT_COUNT=2.
